// File: rtl/arb_pkg.sv
// Shared types for the four-requester decoder grant arbiter.
// State encoding, requester count and grant-index type live here so every block agrees.
package arb_pkg;

   typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int NUM_REQ = 4;

   typedef logic [1:0] req_idx_t;

endpackage : arb_pkg

// File: rtl/Decoder_2_4.sv
// 2-to-4 one-hot decoder with a force-zero input.
// When Reset_In is high every decoded output is held low.
module Decoder_2_4 (
   input  logic       Reset_In,
   input  logic [1:0] Encoded_Value_In,
   output logic [3:0] Decoded_Value_Out
);

   always_comb begin
      // NOTE: assign a default before any branch so no latch is inferred.
      Decoded_Value_Out = '0;
      if (!Reset_In) begin
         Decoded_Value_Out[Encoded_Value_In] = 1'b1;
      end
   end

endmodule : Decoder_2_4

// File: rtl/decoder_grant_arbiter_4.sv
// Round-robin arbiter for four requesters with a bounded grant hold time.
// The registered grant index is decoded to one-hot strobes by Decoder_2_4.
module decoder_grant_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD_CYCLES = 16,
   parameter int HOLD_CNT_W      = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1
) (
   input  logic               Clock_In,
   input  logic               Reset_In,
   input  logic [NUM_REQ-1:0] Request_In,
   input  logic               Done_In,
   output logic               Grant_Valid_Out,
   output logic [1:0]         Grant_Index_Out,
   output logic               Grant_0_Out,
   output logic               Grant_1_Out,
   output logic               Grant_2_Out,
   output logic               Grant_3_Out,
   output logic               Timeout_Out
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST =
      HOLD_CNT_W'((MAX_HOLD_CYCLES > 0) ? MAX_HOLD_CYCLES - 1 : 0);

   arb_state_t             r_state;
   req_idx_t               r_idx;
   req_idx_t               r_ptr;
   logic [HOLD_CNT_W-1:0]  r_hold_cnt;
   logic                   r_timeout;

   arb_state_t             w_state_nxt;
   req_idx_t               w_idx_nxt;
   req_idx_t               w_ptr_nxt;
   logic [HOLD_CNT_W-1:0]  w_hold_cnt_nxt;
   logic                   w_timeout_nxt;
   logic                   w_hold_expired;
   logic                   w_release_normal;
   logic [NUM_REQ-1:0]     w_grant_onehot;

   // First set request bit scanning upward from ptr, wrapping 3 -> 0.
   function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] req, input req_idx_t ptr);
      req_idx_t pick;
      req_idx_t cand;
      logic     found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ptr + req_idx_t'(i);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign w_hold_expired   = (MAX_HOLD_CYCLES != 0) && (r_hold_cnt == HOLD_LAST);
   assign w_release_normal = Done_In || !Request_In[r_idx];

   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_ptr_nxt      = r_ptr;
      w_hold_cnt_nxt = r_hold_cnt;
      w_timeout_nxt  = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (|Request_In) begin
               w_idx_nxt      = rr_pick(Request_In, r_ptr);
               w_state_nxt    = ARB_GRANT;
               w_hold_cnt_nxt = '0;
            end
         end
         ARB_GRANT: begin
            if (w_release_normal || w_hold_expired) begin
               w_state_nxt   = ARB_IDLE;
               w_ptr_nxt     = r_idx + req_idx_t'(1);
               // A coincident Done or withdrawal makes the release a normal one.
               w_timeout_nxt = w_hold_expired && !w_release_normal;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + HOLD_CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge Clock_In) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (Reset_In) begin
         r_state    <= ARB_IDLE;
         r_idx      <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign Grant_Valid_Out = (r_state == ARB_GRANT);
   assign Grant_Index_Out = Grant_Valid_Out ? r_idx : 2'd0;
   assign Timeout_Out     = r_timeout;

   Decoder_2_4 u_decoder (
      .Reset_In          (!Grant_Valid_Out),
      .Encoded_Value_In  (Grant_Index_Out),
      .Decoded_Value_Out (w_grant_onehot)
   );

   assign Grant_0_Out = w_grant_onehot[0];
   assign Grant_1_Out = w_grant_onehot[1];
   assign Grant_2_Out = w_grant_onehot[2];
   assign Grant_3_Out = w_grant_onehot[3];

endmodule : decoder_grant_arbiter_4

// File: tb/tb_decoder_grant_arbiter_4.sv
// Scoreboard bench for decoder_grant_arbiter_4 with MAX_HOLD_CYCLES=4.
// The driver queues the expected outputs for each edge; the monitor pops and compares.
module tb_decoder_grant_arbiter_4;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
      logic       timeout;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic       g_valid;
   logic [1:0] g_idx;
   logic       g0, g1, g2, g3;
   logic       tmo;

   exp_t       exp_q[$];
   int         n_checks;
   int         n_fail;
   int         step_no;

   decoder_grant_arbiter_4 #(.MAX_HOLD_CYCLES(4)) dut (
      .Clock_In        (clk),
      .Reset_In        (rst),
      .Request_In      (req),
      .Done_In         (done),
      .Grant_Valid_Out (g_valid),
      .Grant_Index_Out (g_idx),
      .Grant_0_Out     (g0),
      .Grant_1_Out     (g1),
      .Grant_2_Out     (g2),
      .Grant_3_Out     (g3),
      .Timeout_Out     (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int stp, input logic [3:0] act, input logic [3:0] req_v);
      n_checks++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s step %0d: got %b expected %b", name, stp, act, req_v);
      end
   endtask

   // Apply inputs for the next edge and queue the outputs expected after it.
   task automatic step(input logic r, input logic [3:0] rq, input logic d,
                       input logic ev, input logic [1:0] ei, input logic et);
      exp_t e;
      @(negedge clk);
      rst  = r;
      req  = rq;
      done = d;
      e.valid   = ev;
      e.idx     = ei;
      e.timeout = et;
      exp_q.push_back(e);
   endtask

   // Monitor: compares every edge for which an expectation is queued.
   initial begin
      exp_t       e;
      logic [3:0] onehot;
      step_no = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_no++;
            onehot = e.valid ? (4'b0001 << e.idx) : 4'b0000;
            check("valid",   step_no, {3'b0, g_valid}, {3'b0, e.valid});
            check("index",   step_no, {2'b0, g_idx},   {2'b0, e.idx});
            check("onehot",  step_no, {g3, g2, g1, g0}, onehot);
            check("timeout", step_no, {3'b0, tmo},     {3'b0, e.timeout});
         end
      end
   end

   initial begin
      int budget;
      n_checks = 0;
      n_fail   = 0;
      rst  = 1'b1;
      req  = 4'b1111;
      done = 1'b0;

      // Reset held with all requests pending
      step(1, 4'hF, 0, 0, 2'd0, 0);
      step(1, 4'hF, 0, 0, 2'd0, 0);
      // Release: requester 0 granted one cycle later; rotation 0,1,2,3,0
      step(0, 4'hF, 0, 1, 2'd0, 0);
      step(0, 4'hF, 0, 1, 2'd0, 0);
      step(0, 4'hF, 1, 0, 2'd0, 0);
      step(0, 4'hF, 0, 1, 2'd1, 0);
      step(0, 4'hF, 0, 1, 2'd1, 0);
      step(0, 4'hF, 1, 0, 2'd0, 0);
      step(0, 4'hF, 0, 1, 2'd2, 0);
      step(0, 4'hF, 0, 1, 2'd2, 0);
      step(0, 4'hF, 1, 0, 2'd0, 0);
      step(0, 4'hF, 0, 1, 2'd3, 0);
      step(0, 4'hF, 0, 1, 2'd3, 0);
      step(0, 4'hF, 1, 0, 2'd0, 0);
      step(0, 4'hF, 0, 1, 2'd0, 0);
      step(0, 4'hF, 0, 1, 2'd0, 0);
      step(0, 4'hF, 1, 0, 2'd0, 0);
      // Grant 2 so the pointer lands on 3, then 0011 wraps to 0, then 1
      step(0, 4'b0100, 0, 1, 2'd2, 0);
      step(0, 4'b0100, 1, 0, 2'd0, 0);
      step(0, 4'b0011, 0, 1, 2'd0, 0);
      step(0, 4'b0011, 1, 0, 2'd0, 0);
      step(0, 4'b0011, 0, 1, 2'd1, 0);
      step(0, 4'b0011, 1, 0, 2'd0, 0);
      // Timeout: requester 2 held 4 cycles, one IDLE with pulse, re-grant
      step(0, 4'b0100, 0, 1, 2'd2, 0);
      step(0, 4'b0100, 0, 1, 2'd2, 0);
      step(0, 4'b0100, 0, 1, 2'd2, 0);
      step(0, 4'b0100, 0, 1, 2'd2, 0);
      step(0, 4'b0100, 0, 0, 2'd0, 1);
      step(0, 4'b0100, 0, 1, 2'd2, 0);
      step(0, 4'b0100, 1, 0, 2'd0, 0);
      // Withdrawal by granted requester 1
      step(0, 4'b0010, 0, 1, 2'd1, 0);
      step(0, 4'b0000, 0, 0, 2'd0, 0);
      step(0, 4'b0000, 0, 0, 2'd0, 0);
      // Non-granted bits wiggle; Done coincides with timer expiry
      step(0, 4'b0001, 0, 1, 2'd0, 0);
      step(0, 4'b1001, 0, 1, 2'd0, 0);
      step(0, 4'b0101, 0, 1, 2'd0, 0);
      step(0, 4'b0001, 0, 1, 2'd0, 0);
      step(0, 4'b0001, 1, 0, 2'd0, 0);
      // Done while idle is ignored
      step(0, 4'b0000, 1, 0, 2'd0, 0);
      // Reset mid-grant to 3, pointer returns to 0 (1001 picks 0)
      step(0, 4'b1000, 0, 1, 2'd3, 0);
      step(0, 4'b1000, 0, 1, 2'd3, 0);
      step(1, 4'b1000, 0, 0, 2'd0, 0);
      step(0, 4'b1001, 0, 1, 2'd0, 0);
      step(0, 4'b1000, 0, 0, 2'd0, 0);
      // Reset mid-grant to 3, requester 3 granted again
      step(0, 4'b1000, 0, 1, 2'd3, 0);
      step(1, 4'b1000, 0, 0, 2'd0, 0);
      step(0, 4'b1000, 0, 1, 2'd3, 0);
      step(0, 4'b1000, 1, 0, 2'd0, 0);
      step(0, 4'b0000, 0, 0, 2'd0, 0);

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_decoder_grant_arbiter_4
